// File: rtl/data_mem_pkg.sv
// Shared types and default sizes for the data memory access controller.
package data_mem_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;

    // Controller operating phase: clearing sweep or normal arbitration.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    // Identity of a requester, also used to remember who was served last.
    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_AUX = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is the CPU, bit 1 the auxiliary
// requester. The grant is combinational; only the "last served" marker is
// stored. The marker resets to AUX so that the CPU wins the first contention.
module rr_arb2
    import data_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    req_id_t rr_last_q;
    req_id_t rr_last_d;

    // Pick at most one requester; on contention serve the one not served last.
    always_comb begin
        gnt_o     = 2'b00;
        rr_last_d = rr_last_q;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = (rr_last_q == REQ_AUX) ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end else begin
            gnt_o = 2'b00;
        end
        if (gnt_o[0]) begin
            rr_last_d = REQ_CPU;
        end else if (gnt_o[1]) begin
            rr_last_d = REQ_AUX;
        end else begin
            rr_last_d = rr_last_q;
        end
    end

    // Remember which requester was served most recently.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_q <= REQ_AUX;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-port data memory access controller. Shares the memory port between
// the CPU load/store stage and an auxiliary requester with a round-robin
// grant that is issued in the same cycle as the request.
// Optional feature: define DATA_MEM_CTRL_INIT_EN to add a post-reset sweep
// that writes zero to every entry before any grant is issued.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int unsigned W = DATA_W,
    parameter int unsigned A = ADDR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [A-1:0] cpu_addr,
    input  logic [W-1:0] cpu_wdata,
    output logic         cpu_gnt,
    output logic [W-1:0] cpu_rdata,
    input  logic         aux_req,
    input  logic         aux_we,
    input  logic [A-1:0] aux_addr,
    input  logic [W-1:0] aux_wdata,
    output logic         aux_gnt,
    output logic [W-1:0] aux_rdata,
    output logic         busy,
    output logic [A-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    output logic         mem_re,
    output logic         mem_we,
    input  logic [W-1:0] mem_rdata
);

    logic         run_s;
    logic         init_active_s;
    logic [A-1:0] init_addr_s;
    logic [1:0]   gnt_s;

`ifdef DATA_MEM_CTRL_INIT_EN
    localparam logic         BUSY_IN_RESET = 1'b1;
    localparam logic [A-1:0] CNT_LAST      = {A{1'b1}};
    localparam logic [A-1:0] CNT_ONE       = {{(A-1){1'b0}}, 1'b1};

    ctrl_state_t  state_q;
    logic [A-1:0] init_cnt_q;

    // Sweep every address once after reset, then hand over to arbitration;
    // the counter stops at the last address instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            init_cnt_q <= {A{1'b0}};
        end else begin
            case (state_q)
                INIT: begin
                    if (init_cnt_q == CNT_LAST) begin
                        state_q <= RUN;
                    end else begin
                        init_cnt_q <= init_cnt_q + CNT_ONE;
                    end
                end
                RUN:     state_q <= RUN;
                default: state_q <= INIT;
            endcase
        end
    end

    assign run_s         = (state_q == RUN);
    assign init_active_s = (state_q == INIT);
    assign init_addr_s   = init_cnt_q;
`else
    localparam logic BUSY_IN_RESET = 1'b0;

    assign run_s         = 1'b1;
    assign init_active_s = 1'b0;
    assign init_addr_s   = {A{1'b0}};
`endif

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en_i  (run_s & ~reset),
        .req_i ({aux_req, cpu_req}),
        .gnt_o (gnt_s)
    );

    // Drive the memory port and requester responses; everything is forced
    // quiet while reset is asserted so an unclocked write is dropped.
    always_comb begin
        cpu_gnt   = 1'b0;
        aux_gnt   = 1'b0;
        cpu_rdata = {W{1'b0}};
        aux_rdata = {W{1'b0}};
        busy      = 1'b0;
        mem_addr  = {A{1'b0}};
        mem_wdata = {W{1'b0}};
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        if (reset) begin
            busy = BUSY_IN_RESET;
        end else if (init_active_s) begin
            busy     = 1'b1;
            mem_we   = 1'b1;
            mem_addr = init_addr_s;
        end else if (gnt_s[0]) begin
            cpu_gnt   = 1'b1;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
            mem_re    = ~cpu_we;
            cpu_rdata = cpu_we ? {W{1'b0}} : mem_rdata;
        end else if (gnt_s[1]) begin
            aux_gnt   = 1'b1;
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
            mem_we    = aux_we;
            mem_re    = ~aux_we;
            aux_rdata = aux_we ? {W{1'b0}} : mem_rdata;
        end else begin
            busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a behavioural 256x8 memory attached.
// Works in both builds (DATA_MEM_CTRL_INIT_EN defined or not).
module tb_data_mem_ctrl;

`ifdef DATA_MEM_CTRL_INIT_EN
    localparam logic       INIT_EN = 1'b1;
    localparam logic [7:0] EXP_7F  = 8'h00;
    localparam logic [7:0] EXP_40  = 8'h00;
`else
    localparam logic       INIT_EN = 1'b0;
    localparam logic [7:0] EXP_7F  = 8'h25;   // 8'h5A ^ 8'h7F from the fill
    localparam logic [7:0] EXP_40  = 8'h1A;   // 8'h5A ^ 8'h40 from the fill
`endif

    logic       clk;
    logic       reset;
    logic       cpu_req, cpu_we, cpu_gnt;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       aux_req, aux_we, aux_gnt;
    logic [7:0] aux_addr, aux_wdata, aux_rdata;
    logic       busy, mem_re, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       fill;
    logic [7:0] mem_q [0:255];

    int err_cnt = 0;
    int chk_cnt = 0;

    data_mem_ctrl #(.W(8), .A(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rdata (cpu_rdata),
        .aux_req   (aux_req),
        .aux_we    (aux_we),
        .aux_addr  (aux_addr),
        .aux_wdata (aux_wdata),
        .aux_gnt   (aux_gnt),
        .aux_rdata (aux_rdata),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: known non-zero pattern on fill, else clocked writes.
    always @(posedge clk) begin
        if (fill) begin
            for (int k = 0; k < 256; k++) mem_q[k] <= 8'h5A ^ 8'(k);
        end else if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_q[mem_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cpu(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    endtask

    task automatic drive_aux(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
        aux_req = req; aux_we = we; aux_addr = addr; aux_wdata = wd;
    endtask

`ifdef DATA_MEM_CTRL_INIT_EN
    // Walk the clearing sweep cycle by cycle; stop mid-cycle at stop_at.
    task automatic sweep(input int stop_at, input bit aux_at50);
        logic [7:0] a;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            if (aux_at50 && i == 50) drive_aux(1'b1, 1'b0, 8'h7F, 8'h00);
            #3;
            check("init_sweep", {busy, mem_we, mem_re, cpu_gnt, aux_gnt, mem_addr, mem_wdata},
                  {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a, 8'h00});
            if (i == stop_at) return;
            if (i != 255) next_cycle();
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        fill  = 1'b1;
        drive_cpu(1'b1, 1'b1, 8'h7F, 8'hEE);
        drive_aux(1'b0, 1'b0, 8'h00, 8'h00);
        next_cycle();
        fill = 1'b0;
        #3;
        check("rst_outputs", {cpu_gnt, aux_gnt, mem_we, mem_re, mem_addr, mem_wdata, cpu_rdata, aux_rdata}, 64'h0);
        check("rst_busy", busy, INIT_EN);
        next_cycle();
        reset = 1'b0;
        drive_cpu(1'b1, 1'b0, 8'h7F, 8'h00);
`ifdef DATA_MEM_CTRL_INIT_EN
        cpu_req = 1'b0;
        sweep(100, 1'b0);
        reset = 1'b1;
        #1;
        check("rst_mid_init", {busy, mem_we, mem_addr}, {1'b1, 1'b0, 8'h00});
        next_cycle();
        reset = 1'b0;
        sweep(-1, 1'b1);
        next_cycle();
        #3;
        check("first_run_gnt", {busy, cpu_gnt, aux_gnt, mem_re, mem_we, mem_addr}, {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h7F});
        check("cleared_7f", aux_rdata, EXP_7F);
`else
        #3;
        check("first_cycle_gnt", {busy, cpu_gnt, aux_gnt, mem_re, mem_we, mem_addr}, {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h7F});
        check("first_cycle_rd", cpu_rdata, EXP_7F);
`endif
        // CPU write then read back
        next_cycle();
        drive_aux(1'b0, 1'b0, 8'h00, 8'h00);
        drive_cpu(1'b1, 1'b1, 8'h10, 8'hA5);
        #3;
        check("cpu_wr", {cpu_gnt, aux_gnt, mem_we, mem_re, mem_addr, mem_wdata, cpu_rdata},
              {1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'hA5, 8'h00});
        next_cycle();
        drive_cpu(1'b1, 1'b0, 8'h10, 8'h00);
        #3;
        check("cpu_rd", {cpu_gnt, mem_we, mem_re, mem_addr, cpu_rdata, aux_rdata},
              {1'b1, 1'b0, 1'b1, 8'h10, 8'hA5, 8'h00});
        // AUX alone reads the same location
        next_cycle();
        drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        drive_aux(1'b1, 1'b0, 8'h10, 8'h00);
        #3;
        check("aux_rd", {cpu_gnt, aux_gnt, mem_re, aux_rdata, cpu_rdata}, {1'b0, 1'b1, 1'b1, 8'hA5, 8'h00});
        // Continuous contention alternates starting with CPU
        next_cycle();
        drive_cpu(1'b1, 1'b0, 8'h10, 8'h00);
        for (int k = 0; k < 6; k++) begin
            #3;
            check("contend_gnt", {cpu_gnt, aux_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
            check("contend_rd", {cpu_rdata, aux_rdata}, (k % 2 == 0) ? 16'hA500 : 16'h00A5);
            next_cycle();
        end
        // AUX writes, CPU reads the new value next cycle
        drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        drive_aux(1'b1, 1'b1, 8'h30, 8'hC3);
        #3;
        check("aux_wr", {aux_gnt, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 8'h30, 8'hC3});
        next_cycle();
        drive_aux(1'b0, 1'b0, 8'h00, 8'h00);
        drive_cpu(1'b1, 1'b0, 8'h30, 8'h00);
        #3;
        check("xreq_rd", {cpu_gnt, cpu_rdata}, {1'b1, 8'hC3});
        // Idle cycle: port quiet
        next_cycle();
        drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        #3;
        check("idle", {cpu_gnt, aux_gnt, mem_we, mem_re, mem_addr, mem_wdata}, 20'h0);
        // Reset during a write drops it
        next_cycle();
        drive_cpu(1'b1, 1'b1, 8'h40, 8'h77);
        reset = 1'b1;
        #3;
        check("rst_wr_drop", {cpu_gnt, mem_we}, 2'b00);
        next_cycle();
        reset = 1'b0;
        drive_cpu(1'b1, 1'b0, 8'h40, 8'h00);
        drive_aux(1'b1, 1'b0, 8'h40, 8'h00);
`ifdef DATA_MEM_CTRL_INIT_EN
        sweep(-1, 1'b0);
        next_cycle();
`endif
        #3;
        check("rr_reset_gnt", {cpu_gnt, aux_gnt}, 2'b10);
        check("dropped_wr", cpu_rdata, EXP_40);
        next_cycle();
        drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
        #3;
        check("aux_after", {aux_gnt, aux_rdata}, {1'b1, EXP_40});
        next_cycle();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Single-port access controller for the data memory. It shares the memory's one address/data port between the CPU load/store stage and an auxiliary requester (test loader / DMA), using a two-way round-robin grant. Optionally, it clears all entries after reset. It sits between the requesters and `data_mem`, and owns every `mem_*` control signal.

## Interface
- W, 8, data width (matches memory entry width)
- A, 8, address width; memory depth is 2**A
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU requests an access this cycle
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  A  CPU address
- cpu_wdata  in  W  CPU write data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_rdata  out  W  read data; valid in the cycle cpu_gnt=1 with cpu_we=0, else 0
- aux_req, aux_we, aux_addr, aux_wdata, aux_gnt, aux_rdata: same shape and meaning for the auxiliary requester
- busy  out  1  init sequence in progress; no grants are issued
- mem_addr  out  A  memory address
- mem_wdata  out  W  memory write data
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_rdata  in  W  memory combinational read data

## Operation
- States: INIT, RUN.
  - Reset enters INIT (macro defined) or RUN (macro undefined).
- INIT:
  - Each cycle: mem_we=1, mem_addr=init_cnt, mem_wdata=0, mem_re=0.
  - init_cnt (A bits) resets to 0 and increments each cycle.
  - After the cycle writing address 2**A-1, go to RUN; the counter does not wrap.
  - busy=1 and both grants=0 for all of INIT.
  - Requests are ignored, not queued.
- RUN: busy=0. At most one grant per cycle.
  - Only one requester active: grant it.
  - Both active: grant the requester that is not rr_last.
  - rr_last (0=CPU, 1=aux) resets to 1, so CPU wins the first contention; it updates on every grant.
- Granted access:
  - mem_addr/mem_wdata are taken from the granted requester.
  - mem_we = granted we; mem_re = !granted we.
  - The granted requester's rdata = mem_rdata when reading.
  - Non-granted rdata = 0.
- No grant: mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Requesters hold req/we/addr/wdata stable until they see gnt, then may drop or change them the next cycle.

## Timing
- While reset=1, all outputs are 0, except busy = 1 when the macro is defined.
- Grant latency: combinational. gnt is asserted in the same cycle as req in RUN, and the access completes in that cycle.
  - Write commits at the next clk edge.
  - Read data is valid in the grant cycle.
- Back-to-back accesses from one requester: one per cycle when uncontended. Under continuous contention, each requester gets every other cycle; worst-case wait is 1 cycle.
- Init duration: exactly 2**A cycles after the first edge with reset=0. The first grant is possible in cycle 2**A+1.
- Reset mid-INIT: init_cnt returns to 0 and the full sweep restarts.
- Reset mid-RUN: a pending write not yet clocked is dropped.
- Same-address read by one requester immediately after the other's write returns the new data (write committed at the edge between them).

## Configuration
- DATA_MEM_CTRL_INIT_EN defined:
  - INIT sweep present.
  - Memory contents are all zero before the first grant.
- Undefined:
  - No INIT state or init_cnt.
  - busy tied 0.
  - RUN starts on the first cycle after reset.
  - Memory contents are unspecified until written.

## Structure
- Package data_mem_pkg:
  - `ctrl_state_t` enum {INIT, RUN}.
  - `req_id_t` enum {REQ_CPU, REQ_AUX}.
  - Default W/A localparams.
- Sub-module rr_arb2: two requests in, one-hot grant out, holds rr_last. Reused by the controller.
- The top level holds the FSM, init counter and mux.

## Test plan
- Reset 2 cycles, release (macro defined) -> busy=1 for 256 cycles with mem_we=1, mem_addr 0..255, mem_wdata=0; busy=0 in cycle 257; read of address 0x7F returns 0x00.
- CPU alone writes 0xA5 to 0x10, then reads 0x10 next cycle -> cpu_gnt=1 both cycles, mem_we=1 then mem_re=1, cpu_rdata=0xA5, aux_rdata=0.
- Both request continuously for 6 cycles in RUN -> grant order CPU, AUX, CPU, AUX, CPU, AUX; never both, never neither.
- aux_req asserted during INIT at count 50 and held -> aux_gnt=0 until busy falls, then aux_gnt=1 in the first RUN cycle.
- reset pulsed at init count 100 -> sweep restarts at address 0 and takes a full 256 cycles after release.
- Macro undefined, cpu_req held from release -> busy=0 and cpu_gnt=1 in the first cycle after reset drops.
